// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and size encodings for the Avalon data-RAM master
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        BYTE    = SIZE_BYTE,
        HALF    = SIZE_HALF,
        WORD    = SIZE_WORD,
        ILLEGAL = SIZE_ILLEGAL
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUS  = 2'b01,
        RESP = 2'b10
    } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane enables, store replication and load extension
// Ports:
//   size, offset, sign_ext : access size, byte offset within word, sign-extend loads
//   wdata, readdata        : raw store data and raw Avalon read word
//   byteenable, wdata_rep  : lane enables and lane-replicated store data
//   rdata_ext, misaligned  : extracted/extended load data, alignment fault flag
module mem_lane_align
    import mem_pkg::*;
(
    input  mem_size_t   size,
    input  logic [1:0]  offset,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    input  logic [31:0] readdata,
    output logic [3:0]  byteenable,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = readdata[{offset, 3'b000} +: 8];
    assign half_lane = readdata[{offset[1], 4'b0000} +: 16];

    always_comb begin
        byteenable = 4'b0000;
        wdata_rep  = 32'h0;
        rdata_ext  = 32'h0;
        misaligned = 1'b0;
        case (size)
            BYTE: begin
                byteenable = 4'b0001 << offset;
                wdata_rep  = {4{wdata[7:0]}};
                rdata_ext  = {{24{sign_ext & byte_lane[7]}}, byte_lane};
            end
            HALF: begin
                byteenable = 4'b0011 << offset;
                wdata_rep  = {2{wdata[15:0]}};
                rdata_ext  = {{16{sign_ext & half_lane[15]}}, half_lane};
                misaligned = offset[0];
            end
            WORD: begin
                byteenable = 4'b1111;
                wdata_rep  = wdata;
                rdata_ext  = readdata;
                misaligned = |offset;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/avalon_mem_master.sv
// rtl/avalon_mem_master.sv - CPU load/store to single Avalon-MM transfer master
// Ports:
//   clk, reset                        : clock, synchronous active-high reset
//   req_*                             : CPU request handshake (req_ready high only in IDLE)
//   resp_valid/resp_rdata/resp_error  : one-cycle response pulse with load data / fault
//   address/byteenable/read/write/writedata/waitrequest/readdata : Avalon-MM master side
module avalon_mem_master
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] address,
    output logic [3:0]  byteenable,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    input  logic        waitrequest,
    input  logic [31:0] readdata
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);

    state_t          state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    mem_size_t       size_q, size_n;
    logic [1:0]      off_q, off_n;
    logic            sgn_q, sgn_n;
    logic            read_n, write_n, resp_valid_n, resp_error_n;
    logic [31:0]     address_n, writedata_n, resp_rdata_n;
    logic [3:0]      byteenable_n;

    mem_size_t   al_size;
    logic [1:0]  al_off;
    logic        al_sgn;
    logic [3:0]  al_be;
    logic [31:0] al_wdata, al_rdata;
    logic        al_misaligned;

    // In IDLE the aligner decodes the incoming request; afterwards it works on
    // the latched copy so load extraction uses the accepted size/offset.
    assign al_size = (state == IDLE) ? mem_size_t'(req_size) : size_q;
    assign al_off  = (state == IDLE) ? req_addr[1:0] : off_q;
    assign al_sgn  = (state == IDLE) ? req_signed : sgn_q;

    mem_lane_align u_align (
        .size       (al_size),
        .offset     (al_off),
        .sign_ext   (al_sgn),
        .wdata      (req_wdata),
        .readdata   (readdata),
        .byteenable (al_be),
        .wdata_rep  (al_wdata),
        .rdata_ext  (al_rdata),
        .misaligned (al_misaligned)
    );

    assign req_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            size_q     <= BYTE;
            off_q      <= 2'b00;
            sgn_q      <= 1'b0;
            read       <= 1'b0;
            write      <= 1'b0;
            address    <= 32'h0;
            byteenable <= 4'b0000;
            writedata  <= 32'h0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_error <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            size_q     <= size_n;
            off_q      <= off_n;
            sgn_q      <= sgn_n;
            read       <= read_n;
            write      <= write_n;
            address    <= address_n;
            byteenable <= byteenable_n;
            writedata  <= writedata_n;
            resp_valid <= resp_valid_n;
            resp_rdata <= resp_rdata_n;
            resp_error <= resp_error_n;
        end
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        size_n       = size_q;
        off_n        = off_q;
        sgn_n        = sgn_q;
        read_n       = read;
        write_n      = write;
        address_n    = address;
        byteenable_n = byteenable;
        writedata_n  = writedata;
        resp_valid_n = 1'b0;
        resp_rdata_n = resp_rdata;
        resp_error_n = resp_error;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_size == SIZE_ILLEGAL || al_misaligned) begin
                        state_n      = RESP;
                        resp_valid_n = 1'b1;
                        resp_error_n = 1'b1;
                        resp_rdata_n = 32'h0;
                    end else begin
                        state_n      = BUS;
                        size_n       = mem_size_t'(req_size);
                        off_n        = req_addr[1:0];
                        sgn_n        = req_signed;
                        address_n    = {req_addr[31:2], 2'b00};
                        byteenable_n = al_be;
                        writedata_n  = al_wdata;
                        read_n       = ~req_write;
                        write_n      = req_write;
                    end
                end
            end
            BUS: begin
                if (!waitrequest) begin
                    state_n      = RESP;
                    read_n       = 1'b0;
                    write_n      = 1'b0;
                    resp_valid_n = 1'b1;
                    resp_error_n = 1'b0;
                    resp_rdata_n = write ? 32'h0 : al_rdata;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                    if (TIMEOUT_CYCLES != 0 && cnt_n == TIMEOUT_CNT) begin
                        state_n      = RESP;
                        read_n       = 1'b0;
                        write_n      = 1'b0;
                        resp_valid_n = 1'b1;
                        resp_error_n = 1'b1;
                        resp_rdata_n = 32'h0;
                    end
                end
            end
            RESP: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
